mealy_match_counter: RTL and testbench

Downstream consumer of the two-bit match output of the serial pattern detector (`o[1]` flags "010", `o[0]` flags "101"). Counts both match types over fixed windows of clock cycles, then offers each window's counts as one report on a valid/ready handshake. Report consumers such as a status register or a display driver read from this block instead of sampling raw one-cycle match pulses.

---
 rtl/match_cnt_pkg.sv | 18 +
 rtl/match_cnt_lane.sv | 61 ++++++
 rtl/mealy_match_counter.sv | 173 +++++++++++++++++
 tb/tb_mealy_match_counter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/match_cnt_pkg.sv
// -----------------------------------------------------------------------------
// match_cnt_pkg
// Shared types and constants for the match counter.
//   match_cnt_state_t : controller state (IDLE, RUN)
//   MATCH_010_BIT     : bit of the detector output that flags "010"
//   MATCH_101_BIT     : bit of the detector output that flags "101"
// -----------------------------------------------------------------------------
package match_cnt_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } match_cnt_state_t;

    localparam int MATCH_010_BIT = 1;
    localparam int MATCH_101_BIT = 0;

endpackage : match_cnt_pkg

// File: rtl/match_cnt_lane.sv
// -----------------------------------------------------------------------------
// match_cnt_lane
// One live match counter. The updated value (current count plus this cycle's
// increment) is exposed combinationally so the window-close snapshot can
// include the increment of the closing cycle.
//
// Overflow behaviour:
//   MATCH_CNT_SATURATE_EN defined   : count holds at 2^CNT_W-1
//   MATCH_CNT_SATURATE_EN undefined : count wraps modulo 2^CNT_W
//
// Ports:
//   clock   in   clock, rising edge
//   reset   in   asynchronous, active-high
//   inc     in   add one this cycle
//   clr     in   clear to zero on this edge (wins over inc)
//   cnt_upd out  count including this cycle's increment
// -----------------------------------------------------------------------------
module match_cnt_lane #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt_upd
);

    localparam logic [CNT_W-1:0] CNT_ONE = 1;
`ifdef MATCH_CNT_SATURATE_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
`endif

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_upd;

    always_comb begin
        w_cnt_upd = r_cnt;
        if (inc) begin
`ifdef MATCH_CNT_SATURATE_EN
            if (r_cnt != CNT_MAX) begin
                w_cnt_upd = r_cnt + CNT_ONE;
            end
`else
            w_cnt_upd = r_cnt + CNT_ONE;
`endif
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_upd;
        end
    end

    assign cnt_upd = w_cnt_upd;

endmodule : match_cnt_lane

// File: rtl/mealy_match_counter.sv
// -----------------------------------------------------------------------------
// mealy_match_counter
// Counts "010" and "101" detector matches over fixed windows of WINDOW clock
// cycles and offers each window's counts as one report on a valid/ready
// handshake. A window close while a report is stalled drops the new snapshot
// and sets a sticky overrun flag.
//
// Build option: MATCH_CNT_SATURATE_EN (saturating instead of wrapping counters).
//
// Parameters:
//   WINDOW  cycles per report window (>= 2)
//   CNT_W   width of each match counter
//
// Ports:
//   clock       in   clock, rising edge
//   reset       in   asynchronous, active-high
//   start       in   pulse; begin counting (ignored while running)
//   stop        in   pulse; close current window early and stop (ignored idle)
//   match[1:0]  in   detector output, bit1 = "010", bit0 = "101"
//   rpt_valid   out  report pending
//   rpt_ready   in   consumer accepts report
//   rpt_cnt010  out  "010" count of reported window
//   rpt_cnt101  out  "101" count of reported window
//   overrun     out  sticky, a report was lost
//   busy        out  high while counting
//
// state | meaning
// ------+---------------------------------------------
// IDLE  | reset state, match input ignored
// RUN   | counting matches, windows close periodically
// -----------------------------------------------------------------------------
module mealy_match_counter
    import match_cnt_pkg::*;
#(
    parameter int WINDOW = 16,
    parameter int CNT_W  = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic [1:0]       match,
    output logic             rpt_valid,
    input  logic             rpt_ready,
    output logic [CNT_W-1:0] rpt_cnt010,
    output logic [CNT_W-1:0] rpt_cnt101,
    output logic             overrun,
    output logic             busy
);

    localparam int              WIN_W    = (WINDOW > 2) ? $clog2(WINDOW) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
    localparam logic [WIN_W-1:0] WIN_ONE  = WIN_W'(1);

    match_cnt_state_t r_state;
    match_cnt_state_t w_state_nxt;

    logic             w_run;
    logic             w_close;
    logic             w_xfer;
    logic             w_load;
    logic             w_lost;

    logic [WIN_W-1:0] r_win;
    logic [CNT_W-1:0] w_cnt010_upd;
    logic [CNT_W-1:0] w_cnt101_upd;

    logic             r_rpt_valid;
    logic [CNT_W-1:0] r_rpt_cnt010;
    logic [CNT_W-1:0] r_rpt_cnt101;
    logic             r_overrun;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_run       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_run = 1'b1;
                if (stop) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------- window timer
    // stop on the last cycle of a window is still a single close.
    assign w_close = w_run && ((r_win == WIN_LAST) || stop);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_win <= '0;
        end else if (w_close) begin
            r_win <= '0;
        end else if (w_run) begin
            r_win <= r_win + WIN_ONE;
        end
    end

    // ------------------------------------------------------- live counters
    match_cnt_lane #(
        .CNT_W (CNT_W)
    ) u_lane_010 (
        .clock   (clock),
        .reset   (reset),
        .inc     (w_run && match[MATCH_010_BIT]),
        .clr     (w_close),
        .cnt_upd (w_cnt010_upd)
    );

    match_cnt_lane #(
        .CNT_W (CNT_W)
    ) u_lane_101 (
        .clock   (clock),
        .reset   (reset),
        .inc     (w_run && match[MATCH_101_BIT]),
        .clr     (w_close),
        .cnt_upd (w_cnt101_upd)
    );

    // ------------------------------------------------------ report register
    // A close may load when the slot is empty or is being emptied this edge;
    // otherwise the pending report wins and the new snapshot is dropped.
    assign w_xfer = r_rpt_valid && rpt_ready;
    assign w_load = w_close && (!r_rpt_valid || rpt_ready);
    assign w_lost = w_close && r_rpt_valid && !rpt_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rpt_valid  <= 1'b0;
            r_rpt_cnt010 <= '0;
            r_rpt_cnt101 <= '0;
        end else if (w_load) begin
            r_rpt_valid  <= 1'b1;
            r_rpt_cnt010 <= w_cnt010_upd;
            r_rpt_cnt101 <= w_cnt101_upd;
        end else if (w_xfer) begin
            r_rpt_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_overrun <= 1'b0;
        end else if (w_lost) begin
            r_overrun <= 1'b1;
        end
    end

    assign rpt_valid  = r_rpt_valid;
    assign rpt_cnt010 = r_rpt_cnt010;
    assign rpt_cnt101 = r_rpt_cnt101;
    assign overrun    = r_overrun;
    assign busy       = (r_state == RUN);

endmodule : mealy_match_counter

// File: tb/tb_mealy_match_counter.sv
// -----------------------------------------------------------------------------
// tb_mealy_match_counter
// Directed scenarios followed by random traffic, every cycle checked against
// a window/report model built from integer match tallies.
// -----------------------------------------------------------------------------
module tb_mealy_match_counter;

    localparam int WINDOW = 5;
    localparam int CNT_W  = 2;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic [1:0]       match = 2'b00;
    logic             rpt_ready = 1'b0;
    logic             rpt_valid;
    logic [CNT_W-1:0] rpt_cnt010;
    logic [CNT_W-1:0] rpt_cnt101;
    logic             overrun;
    logic             busy;

    int n_cmp = 0;
    int n_bad = 0;

    // model state: tallies are unbounded, folded to CNT_W only when reported
    bit m_run, m_valid, m_ovr;
    int m_cyc, m_n010, m_n101, m_r010, m_r101;

    mealy_match_counter #(
        .WINDOW (WINDOW),
        .CNT_W  (CNT_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .match      (match),
        .rpt_valid  (rpt_valid),
        .rpt_ready  (rpt_ready),
        .rpt_cnt010 (rpt_cnt010),
        .rpt_cnt101 (rpt_cnt101),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    function automatic int fold(int n);
`ifdef MATCH_CNT_SATURATE_EN
        return (n > CMAX) ? CMAX : n;
`else
        return n % (CMAX + 1);
`endif
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_valid = 0; m_ovr = 0;
        m_cyc = 0; m_n010 = 0; m_n101 = 0; m_r010 = 0; m_r101 = 0;
    endtask

    // Applies the inputs present at a rising edge to the model.
    task automatic model_edge();
        bit was_run;
        bit close;
        was_run = m_run;
        close   = 0;
        if (was_run) begin
            m_n010 += int'(match[1]);
            m_n101 += int'(match[0]);
            m_cyc++;
            close = (m_cyc == WINDOW) || stop;
        end
        if (close) begin
            if (m_valid && !rpt_ready) begin
                m_ovr = 1;
            end else begin
                m_valid = 1;
                m_r010  = fold(m_n010);
                m_r101  = fold(m_n101);
            end
            m_n010 = 0; m_n101 = 0; m_cyc = 0;
        end else if (m_valid && rpt_ready) begin
            m_valid = 0;
        end
        if (was_run && stop) m_run = 0;
        else if (!was_run && start) m_run = 1;
    endtask

    task automatic check_outputs(string tag);
        chk({tag, ".busy"},    32'(busy),       32'(m_run));
        chk({tag, ".valid"},   32'(rpt_valid),  32'(m_valid));
        chk({tag, ".overrun"}, 32'(overrun),    32'(m_ovr));
        chk({tag, ".cnt010"},  32'(rpt_cnt010), 32'(m_r010));
        chk({tag, ".cnt101"},  32'(rpt_cnt101), 32'(m_r101));
    endtask

    // Drive one cycle of inputs, clock it, then check 1 time unit later.
    task automatic cyc(string tag, bit st, bit sp, logic [1:0] m, bit rdy);
        start = st; stop = sp; match = m; rpt_ready = rdy;
        @(posedge clock);
        model_edge();
        #1;
        check_outputs(tag);
    endtask

    logic [9:0] bitstream;
    logic [2:0] hist;

    initial begin
        model_reset();
        #2;
        check_outputs("reset");
        @(posedge clock);
        #1;
        check_outputs("reset_hold");
        #2 reset = 1'b0;

        // basic window, consumer always ready
        cyc("basic", 1, 0, 2'b00, 1);
        cyc("basic", 0, 0, 2'b10, 1);
        cyc("basic", 0, 0, 2'b01, 1);
        cyc("basic", 0, 0, 2'b11, 1);
        cyc("basic", 0, 0, 2'b00, 1);
        cyc("basic", 0, 0, 2'b00, 1);
        cyc("basic", 1, 0, 2'b11, 1);
        cyc("basic", 0, 1, 2'b00, 1);
        cyc("basic", 0, 0, 2'b00, 1);

        // backpressure across two closes, then drain
        cyc("bp", 1, 0, 2'b00, 0);
        for (int i = 0; i < 2 * WINDOW + 1; i++) begin
            cyc("bp", 0, 0, 2'(i % 4), 0);
        end
        cyc("bp", 0, 0, 2'b00, 1);
        cyc("bp", 0, 1, 2'b01, 1);
        cyc("bp", 0, 0, 2'b00, 1);

        // early stop after three "101"
        cyc("early", 1, 0, 2'b00, 1);
        cyc("early", 0, 0, 2'b01, 1);
        cyc("early", 0, 0, 2'b01, 1);
        cyc("early", 0, 1, 2'b01, 1);
        cyc("early", 0, 1, 2'b11, 0);
        cyc("early", 0, 0, 2'b11, 1);
        cyc("early", 0, 0, 2'b11, 1);

        // overflow: "010" every cycle of a full window
        cyc("ovf", 1, 0, 2'b00, 1);
        for (int i = 0; i < WINDOW; i++) cyc("ovf", 0, 0, 2'b10, 0);
        cyc("ovf", 0, 1, 2'b10, 1);
        cyc("ovf", 0, 0, 2'b00, 1);

        // async reset mid-cycle with a report pending
        cyc("ar", 1, 0, 2'b00, 0);
        for (int i = 0; i < WINDOW; i++) cyc("ar", 0, 0, 2'b11, 0);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_outputs("ar_async");
        #3 reset = 1'b0;
        for (int i = 0; i < 3; i++) cyc("ar_idle", 0, 0, 2'b11, 1);
        cyc("ar_restart", 1, 0, 2'b00, 1);

        // chained with a serial detector on a fixed bitstream
        cyc("chain", 0, 1, 2'b00, 1);
        cyc("chain", 0, 0, 2'b00, 1);
        bitstream = 10'b0110101011;
        hist = 3'b000;
        cyc("chain", 1, 0, 2'b00, 1);
        for (int i = 9; i >= 0; i--) begin
            hist = {hist[1:0], bitstream[i]};
            cyc("chain", 0, 0, {hist == 3'b010, hist == 3'b101}, 1);
        end
        cyc("chain", 0, 1, 2'b00, 1);
        cyc("chain", 0, 0, 2'b00, 1);

        // random traffic
        for (int i = 0; i < 800; i++) begin
            cyc("rand", $urandom_range(0, 7) == 0, $urandom_range(0, 19) == 0,
                2'($urandom_range(0, 3)), $urandom_range(0, 3) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_mealy_match_counter
